// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/word/state sizes, the FIPS-197 S-box,
// GF(2^8) arithmetic helpers and the round sequencer FSM encoding.
package aes_pkg;

  localparam int NB_BYTE       = 8;
  localparam int N_BYTES_WORD  = 4;
  localparam int N_BYTES_STATE = 16;
  localparam int NB_WORD       = NB_BYTE * N_BYTES_WORD;
  localparam int NB_STATE      = 128;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_RUN  = 1'b1
  } fsm_state_e;

  // Table entry x sits at byte position 255-x from the bottom, i.e. ~x.
  function automatic logic [NB_BYTE-1:0] sbox(input logic [NB_BYTE-1:0] x);
    return SBOX_TABLE[NB_BYTE*int'(~x) +: NB_BYTE];
  endfunction

  function automatic logic [NB_BYTE-1:0] xtime(input logic [NB_BYTE-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [NB_BYTE-1:0] gf_mul(input logic [NB_BYTE-1:0] a,
                                                input logic [NB_BYTE-1:0] b);
    logic [NB_BYTE-1:0] acc;
    logic [NB_BYTE-1:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < NB_BYTE; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // One state column, row 0 in the most significant byte.
  function automatic logic [NB_WORD-1:0] mix_column(input logic [NB_WORD-1:0] col);
    logic [NB_BYTE-1:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
            gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02)};
  endfunction

endpackage

// File: rtl/aes_round_function.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped on the final round) and AddRoundKey. Byte 0 is the MSB and the
// state is column-major, so byte i is row i%4 of column i/4.
module aes_round_function
  import aes_pkg::*;
(
  input  logic [NB_STATE-1:0] i_state,
  input  logic [NB_STATE-1:0] i_round_key,
  input  logic                i_last_round,
  output logic [NB_STATE-1:0] o_state
);

  logic [NB_STATE-1:0] sub_bytes;
  logic [NB_STATE-1:0] shift_rows;
  logic [NB_STATE-1:0] mix_cols;

  // S-box substitution of all sixteen state bytes
  always_comb begin
    sub_bytes = '0;
    for (int i = 0; i < N_BYTES_STATE; i++) begin
      sub_bytes[NB_STATE-1-NB_BYTE*i -: NB_BYTE] =
        sbox(i_state[NB_STATE-1-NB_BYTE*i -: NB_BYTE]);
    end
  end

  // Row r rotates left by r columns
  always_comb begin
    shift_rows = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[NB_STATE-1-NB_BYTE*(4*c+r) -: NB_BYTE] =
          sub_bytes[NB_STATE-1-NB_BYTE*(4*((c+r)%4)+r) -: NB_BYTE];
      end
    end
  end

  // Column mixing, then the round key is added on either path
  always_comb begin
    mix_cols = '0;
    for (int c = 0; c < 4; c++) begin
      mix_cols[NB_STATE-1-NB_WORD*c -: NB_WORD] =
        mix_column(shift_rows[NB_STATE-1-NB_WORD*c -: NB_WORD]);
    end
    o_state = (i_last_round ? shift_rows : mix_cols) ^ i_round_key;
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption core: one round per enabled clock using round keys
// supplied by the upstream key scheduler, with a start/done handshake.
module aes_round_sequencer #(
  parameter int NB_BYTE       = 8,
  parameter int N_BYTES_STATE = 16,
  parameter int N_ROUNDS      = 14
) (
  input  logic                                         i_clock,
  input  logic                                         i_reset,
  input  logic                                         i_valid,
  input  logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1)-1:0] i_round_key_vector,
  input  logic                                         i_keys_ready,
  input  logic                                         i_key_update,
  input  logic                                         i_start,
  input  logic [N_BYTES_STATE*NB_BYTE-1:0]             i_plaintext,
  output logic [N_BYTES_STATE*NB_BYTE-1:0]             o_ciphertext,
  output logic                                         o_done,
  output logic                                         o_busy,
  output logic                                         o_keys_valid
);
  import aes_pkg::*;

  localparam int NB_BLOCK = N_BYTES_STATE * NB_BYTE;
  localparam int NB_ROUND = $clog2(N_ROUNDS + 1);
  localparam logic [NB_ROUND-1:0] LAST_ROUND = NB_ROUND'(N_ROUNDS);

  // The datapath is built for 8-bit bytes, 16-byte blocks and standard key sizes
  if (NB_BYTE != 8) begin : g_bad_nb_byte
    $error("aes_round_sequencer: NB_BYTE must be 8");
  end
  if (N_BYTES_STATE != 16) begin : g_bad_n_bytes_state
    $error("aes_round_sequencer: N_BYTES_STATE must be 16");
  end
  if (N_ROUNDS != 10 && N_ROUNDS != 12 && N_ROUNDS != 14) begin : g_bad_n_rounds
    $error("aes_round_sequencer: N_ROUNDS must be 10, 12 or 14");
  end

  fsm_state_e          fsm_q, fsm_d;
  logic [NB_ROUND-1:0] round_q, round_d;
  logic [NB_BLOCK-1:0] block_q, block_d;
  logic [NB_BLOCK-1:0] ciphertext_d;
  logic                done_d;
  logic                busy_d;
  logic                keys_valid_d;
  logic [NB_BLOCK-1:0] round_key;
  logic                last_round;
  logic [NB_BLOCK-1:0] round_out;

  assign round_key  = i_round_key_vector[round_q*NB_BLOCK +: NB_BLOCK];
  assign last_round = (round_q == LAST_ROUND);

  aes_round_function u_round_function (
    .i_state      (block_q),
    .i_round_key  (round_key),
    .i_last_round (last_round),
    .o_state      (round_out)
  );

  // Register bank; every register, including the outputs, holds while i_valid is low
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      fsm_q        <= FSM_IDLE;
      round_q      <= '0;
      block_q      <= '0;
      o_ciphertext <= '0;
      o_done       <= 1'b0;
      o_busy       <= 1'b0;
      o_keys_valid <= 1'b0;
    end else if (i_valid) begin
      fsm_q        <= fsm_d;
      round_q      <= round_d;
      block_q      <= block_d;
      o_ciphertext <= ciphertext_d;
      o_done       <= done_d;
      o_busy       <= busy_d;
      o_keys_valid <= keys_valid_d;
    end
  end

  // Next-state logic: key flag tracking, round sequencing, completion and abort
  always_comb begin
    fsm_d        = fsm_q;
    round_d      = round_q;
    block_d      = block_q;
    ciphertext_d = o_ciphertext;
    done_d       = 1'b0;
    busy_d       = o_busy;
    keys_valid_d = o_keys_valid;

    if (i_key_update) begin
      keys_valid_d = 1'b0;
    end else if (i_keys_ready) begin
      keys_valid_d = 1'b1;
    end

    case (fsm_q)
      FSM_IDLE: begin
        if (i_start && o_keys_valid && !i_key_update) begin
          block_d = i_plaintext ^ i_round_key_vector[0 +: NB_BLOCK];
          round_d = NB_ROUND'(1);
          busy_d  = 1'b1;
          fsm_d   = FSM_RUN;
        end
      end
      FSM_RUN: begin
        if (i_key_update) begin
          round_d = '0;
          busy_d  = 1'b0;
          fsm_d   = FSM_IDLE;
        end else if (last_round) begin
          ciphertext_d = round_out;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          round_d      = '0;
          fsm_d        = FSM_IDLE;
        end else begin
          block_d = round_out;
          round_d = round_q + NB_ROUND'(1);
        end
      end
      default: begin
        fsm_d = FSM_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: FIPS-197 C.3 vector, clock
// enable gating, key guard, abort, back-to-back and asynchronous reset.
module tb_aes_round_sequencer;

  localparam int NR      = 14;
  localparam int NB_KEYS = 128 * (NR + 1);

  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid = 1'b1;
  logic [NB_KEYS-1:0] key_vec = '0;
  logic               keys_ready = 1'b0;
  logic               key_update = 1'b0;
  logic               start = 1'b0;
  logic [127:0]       plaintext = '0;
  logic [127:0]       ciphertext;
  logic               done;
  logic               busy;
  logic               keys_valid;

  int  checks = 0;
  int  errors = 0;
  int  en_edges = 0;
  bit  last_en = 1'b0;
  int  start_edge = 0;
  int  done_count = 0;
  bit  done_prev = 1'b0;
  bit  gate = 1'b0;

  logic [7:0]   sbox_tb [256];
  logic [127:0] sb_q [$];

  always #5 clk = ~clk;

  aes_round_sequencer #(
    .NB_BYTE       (8),
    .N_BYTES_STATE (16),
    .N_ROUNDS      (NR)
  ) dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_valid            (valid),
    .i_round_key_vector (key_vec),
    .i_keys_ready       (keys_ready),
    .i_key_update       (key_update),
    .i_start            (start),
    .i_plaintext        (plaintext),
    .o_ciphertext       (ciphertext),
    .o_done             (done),
    .o_busy             (busy),
    .o_keys_valid       (keys_valid)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  function automatic logic [7:0] sboxCalc(input int v);
    logic [7:0] inv;
    inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] t);
    return {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
  endfunction

  function automatic logic [NB_KEYS-1:0] expandKey(input logic [255:0] key);
    logic [31:0]        w [60];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [NB_KEYS-1:0] v;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-8] ^ t;
    end
    v = '0;
    for (int r = 0; r <= NR; r++) v[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return v;
  endfunction

  function automatic logic [127:0] aesEncrypt(input logic [127:0] pt, input logic [NB_KEYS-1:0] rkv);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    blk = pt ^ rkv[127:0];
    for (int r = 1; r <= NR; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tb[blk[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
      if (r < NR) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
      blk = blk ^ rkv[r*128 +: 128];
    end
    return blk;
  endfunction

  // ---------------- edge bookkeeping and output monitor ----------------
  // Counts enabled edges so latency is measured in enabled cycles
  always @(posedge clk) begin
    last_en = valid && !rst;
    if (valid && !rst) en_edges++;
  end

  // Scoreboard: each rising o_done pops one expected block
  always @(negedge clk) begin
    logic [127:0] exp_ct;
    if (done === 1'b1 && !done_prev) begin
      done_count++;
      checks++;
      assert (sb_q.size() > 0) else begin
        errors++;
        $error("FAIL done_unexpected observed=done expected=no_done ct=%h", ciphertext);
      end
      if (sb_q.size() > 0) begin
        exp_ct = sb_q.pop_front();
        checks++;
        assert (ciphertext === exp_ct) else begin
          errors++;
          $error("FAIL done_ciphertext observed=%h expected=%h", ciphertext, exp_ct);
        end
        checks++;
        assert ((en_edges - start_edge) === NR) else begin
          errors++;
          $error("FAIL done_latency observed=%0d expected=%0d", en_edges - start_edge, NR);
        end
      end
    end
    done_prev = (done === 1'b1);
  end

  // ---------------- tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (gate) valid = 1'($urandom_range(0, 1));
  endtask

  task automatic nextEnabled();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_en && n < 100);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds i_start for exactly one enabled edge; accepted starts are scoreboarded
  task automatic applyStimulus(input logic [127:0] pt, input bit expect_accept,
                               input logic [127:0] exp_ct);
    start     = 1'b1;
    plaintext = pt;
    nextEnabled();
    start = 1'b0;
    if (expect_accept) begin
      start_edge = en_edges;
      sb_q.push_back(exp_ct);
    end
  endtask

  // Waits for o_done; returns the number of enabled cycles o_busy was seen high
  task automatic waitDone(input string tag, output int busy_n);
    int n;
    n      = 0;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (last_en && busy === 1'b1) busy_n++;
    end
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end
  endtask

  task automatic loadKeys();
    keys_ready = 1'b1;
    nextEnabled();
    keys_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int           busy_n;
    int           done_before;
    logic [127:0] pt2;
    logic [127:0] ct_before;

    for (int v = 0; v < 256; v++) sbox_tb[v] = sboxCalc(v);
    key_vec = expandKey(KEY_C3);
    $display("[TB] key schedule built, starting sequence");

    // Reset state
    repeat (3) tick();
    checkOutput("reset_ciphertext", ciphertext, '0);
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_keys_valid", 128'(keys_valid), 128'(0));
    rst = 1'b0;
    tick();

    // Key guard: start before keys are loaded is ignored
    done_before = done_count;
    applyStimulus(PT_C3, 1'b0, '0);
    checkOutput("guard_nokeys_busy", 128'(busy), 128'(0));
    repeat (20) tick();
    checkOutput("guard_nokeys_done", 128'(done_count), 128'(done_before));

    // Start on the same edge as keys_ready is ignored
    keys_ready = 1'b1;
    start      = 1'b1;
    plaintext  = PT_C3;
    nextEnabled();
    keys_ready = 1'b0;
    start      = 1'b0;
    checkOutput("guard_same_edge_keys_valid", 128'(keys_valid), 128'(1));
    checkOutput("guard_same_edge_busy", 128'(busy), 128'(0));

    // Start on the following edge is accepted: FIPS-197 C.3
    applyStimulus(PT_C3, 1'b1, CT_C3);
    waitDone("c3", busy_n);
    checkOutput("c3_busy_cycles", 128'(busy_n), 128'(NR));
    checkOutput("c3_busy_low_at_done", 128'(busy), 128'(0));
    nextEnabled();
    checkOutput("c3_done_single_pulse", 128'(done), 128'(0));
    checkOutput("c3_ciphertext_holds", ciphertext, CT_C3);

    // Same vector with i_valid toggled pseudo-randomly
    gate = 1'b1;
    applyStimulus(PT_C3, 1'b1, CT_C3);
    waitDone("gated", busy_n);
    checkOutput("gated_busy_enabled_cycles", 128'(busy_n), 128'(NR));
    repeat (5) tick();
    gate  = 1'b0;
    valid = 1'b1;
    tick();

    // Abort at round 7 via key update
    ct_before   = ciphertext;
    done_before = done_count;
    applyStimulus(128'hdeadbeef_01234567_89abcdef_cafef00d, 1'b0, '0);
    repeat (6) nextEnabled();
    checkOutput("abort_busy_before", 128'(busy), 128'(1));
    key_update = 1'b1;
    nextEnabled();
    key_update = 1'b0;
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_keys_valid", 128'(keys_valid), 128'(0));
    checkOutput("abort_ciphertext", ciphertext, ct_before);
    applyStimulus(PT_C3, 1'b0, '0);
    checkOutput("abort_restart_busy", 128'(busy), 128'(0));
    repeat (20) tick();
    checkOutput("abort_no_done", 128'(done_count), 128'(done_before));

    // Back-to-back: second start on the done cycle, start during RUN ignored
    loadKeys();
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(PT_C3, 1'b1, CT_C3);
    waitDone("b2b_first", busy_n);
    checkOutput("b2b_first_busy_cycles", 128'(busy_n), 128'(NR));
    applyStimulus(pt2, 1'b1, aesEncrypt(pt2, key_vec));
    checkOutput("b2b_second_busy", 128'(busy), 128'(1));
    repeat (3) tick();
    applyStimulus(128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0, '0);
    waitDone("b2b_second", busy_n);
    tick();

    // Asynchronous reset between edges in the middle of a run
    applyStimulus(PT_C3, 1'b0, '0);
    repeat (5) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("areset_ciphertext", ciphertext, '0);
    checkOutput("areset_done", 128'(done), 128'(0));
    checkOutput("areset_busy", 128'(busy), 128'(0));
    checkOutput("areset_keys_valid", 128'(keys_valid), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    loadKeys();
    checkOutput("areset_reload_keys_valid", 128'(keys_valid), 128'(1));
    applyStimulus(PT_C3, 1'b1, CT_C3);
    waitDone("areset_rerun", busy_n);
    checkOutput("areset_rerun_busy_cycles", 128'(busy_n), 128'(NR));
    repeat (3) tick();

    checkOutput("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES encryption core that sits directly downstream of the sequential key scheduler. It consumes the flat round-key vector and the scheduler's ready pulse. It then applies one AES round per enabled clock to a 128-bit input block and returns the ciphertext with a one-cycle done pulse. It feeds the GHASH/GCTR datapath, which sees a simple start/done block cipher.

## Interface

Parameters:
- NB_BYTE, 8, bits per byte; any other value is a configuration error.
- N_BYTES_STATE, 16, bytes per state/round key.
- N_ROUNDS, 14, number of AES rounds (10/12/14 supported).

Ports:
- i_clock, in, 1, single clock; all registers on rising edge.
- i_reset, in, 1, asynchronous, active-high reset.
- i_valid, in, 1, clock enable; when low, all state, including the FSM and every output, holds.
- i_round_key_vector, in, N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1), round key r at [r*128 +: 128]; byte 0 of each key is at the MSB.
- i_keys_ready, in, 1, scheduler done pulse; the vector is stable from that pulse onward.
- i_key_update, in, 1, same signal that retriggers the scheduler; invalidates keys.
- i_start, in, 1, request to encrypt i_plaintext.
- i_plaintext, in, 128, input block; byte 0 is at the MSB.
- o_ciphertext, out, 128, result; holds its value until the next completion.
- o_done, out, 1, one enabled-cycle pulse when o_ciphertext is updated.
- o_busy, out, 1, high while rounds are in progress.
- o_keys_valid, out, 1, keys have been loaded and not invalidated.

## Operation

- Reset values: FSM = IDLE, round counter = 0, state = 0, o_ciphertext = 0, o_done = 0, o_busy = 0, o_keys_valid = 0.
- All of the actions below occur only on edges where i_valid = 1.
- Keys flag:
  - set on i_keys_ready;
  - cleared on i_key_update;
  - if both are high on the same edge, the flag is cleared.
- FSM states: IDLE and RUN.
- IDLE → RUN on i_start && o_keys_valid && !i_key_update:
  - state <= i_plaintext ^ rk[0];
  - round <= 1;
  - o_busy <= 1.
- RUN, round < N_ROUNDS:
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[round];
  - round++.
- RUN, round == N_ROUNDS:
  - o_ciphertext <= ShiftRows(SubBytes(state)) ^ rk[N_ROUNDS];
  - o_done <= 1;
  - o_busy <= 0;
  - FSM → IDLE.
- o_done is cleared on the next enabled edge.
- i_start while in RUN is ignored; it is not queued.
- i_start with o_keys_valid = 0 is ignored.
- i_start on the same edge as i_keys_ready is ignored, because the flag is not yet set when sampled.
- i_key_update during RUN aborts to IDLE:
  - o_busy <= 0;
  - no o_done;
  - o_ciphertext is unchanged.
- An asynchronous i_reset mid-operation returns all registers to their reset values immediately.
- Round counter width is clog2(N_ROUNDS+1); round-key selection is an indexed part-select by round.

## Timing

- Latency: i_start sampled at enabled edge k gives o_done = 1 and a valid o_ciphertext after enabled edge k + N_ROUNDS (14 enabled cycles for AES-256).
- Throughput: one block per N_ROUNDS+1 enabled cycles. A new i_start is accepted on the edge where o_done rises, because the FSM is already IDLE.
- i_valid low cycles stretch the latency exactly, with no state loss.
- o_busy is registered. It is high from edge k through edge k+N_ROUNDS-1 inclusive.

## Structure

- Shared package aes_pkg holds:
  - NB_BYTE, N_BYTES_WORD, NB_STATE = 128;
  - the FIPS-197 S-box constant table;
  - the xtime/GF(2^8) multiply function;
  - FSM state encodings.
- One sub-module is natural: aes_round_function. It is purely combinational and has i_state, i_round_key, i_last_round and o_state. It instantiates the existing 16-byte S-box LUT and performs ShiftRows, conditional MixColumns and AddRoundKey.
- The top level holds the FSM, round counter, keys flag and output registers.

## Test plan

- FIPS-197 C.3 vector:
  - stimulus: key 000102…1f from the scheduler, i_keys_ready pulse, then i_start with pt 00112233445566778899aabbccddeeff;
  - required: o_ciphertext = 8ea2b7ca516745bfeafc49904b496089 and o_done high exactly 14 enabled cycles after the start edge;
  - required: o_busy high for 14 cycles.
- Gating: the same vector with i_valid toggled pseudo-randomly at 50% → identical ciphertext, with latency equal to 14 enabled edges.
- Key guard:
  - i_start before i_keys_ready → no busy, no done;
  - i_start on the same edge as i_keys_ready → ignored;
  - i_start on the next edge → accepted.
- Abort: i_key_update at round 7 → o_busy drops, no o_done, o_ciphertext keeps its prior value, o_keys_valid = 0, and a subsequent i_start is ignored.
- Back-to-back:
  - second i_start on the o_done edge → second ciphertext 14 cycles later;
  - i_start during RUN → ignored.
- Reset: i_reset asserted asynchronously mid-RUN (between edges) → all outputs go to 0 immediately, and operation is correct after deassertion and a reload of the keys.
